// File: rtl/rv_elastic_fifo_pkg.sv
// Shared helpers for the elastic FIFO slice.
// No timing of its own; elaboration-time helpers only.
// No handshake; nothing to backpressure.
package rv_elastic_fifo_pkg;

   // True when v is a positive power of two.
   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/rv_elastic_fifo_if.sv
// Generic valid/ready handshake bundle shared by producer and consumer.
// Combinational wires only; adds no latency.
// Sender holds valid/data until ready is seen high at a clock edge.
interface rv_if #(
   parameter int DW = 32
);
   logic          valid;
   logic [DW-1:0] data;
   logic          ready;

   // Receiving side: samples valid/data, drives ready.
   modport RX (input valid, input data, output ready);
   // Transmitting side: drives valid/data, samples ready.
   modport TX (output valid, output data, input ready);
endinterface

// File: rtl/rv_elastic_fifo_mem.sv
// DEPTH x DW register array, one synchronous write port, asynchronous read.
// Write visible on rdata the cycle after we; read is combinational.
// No handshake; the owner decides when to write. Contents are never reset.
module rv_fifo_mem #(
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   // Next array contents: only the addressed entry changes on a write.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage register; deliberately without reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/rv_elastic_fifo.sv
// Valid/ready elastic FIFO with flush, occupancy count and high-water mark.
// Latency 1 cycle (PASSTHRU=0), 0 cycles when PASSTHRU=1 and empty.
// in.ready depends only on full/flush/rst, never on out.ready; full refuses input.
module rv_elastic_fifo
   import rv_elastic_fifo_pkg::*;
#(
   parameter int DW       = 32,
   parameter int DEPTH    = 4,
   parameter bit PASSTHRU = 1'b0,
   parameter int CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   rv_if.RX              in,
   rv_if.TX              out,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] hwm
);

   localparam int AW = $clog2(DEPTH);

   // Pointer wrap relies on DEPTH being a power of two.
   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("rv_elastic_fifo: DEPTH must be a power of two and >= 2");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] hwm_q, hwm_d;
   logic [DW-1:0] rdata;
   logic          in_rdy, out_vld;
   logic [DW-1:0] out_dat;
   logic          bypass, enq, deq, bypass_take, wr_en, rd_en;

   // Handshake, bypass selection and qualified read/write strobes.
   always_comb begin
      full   = (count_q == CW'(DEPTH));
      empty  = (count_q == '0);
      bypass = PASSTHRU && empty;
      in_rdy = !full && !flush && !rst;
      if (bypass) begin
         // Gate with flush/rst so the consumer never takes a beat the producer did not hand over.
         out_vld = in.valid && !flush && !rst;
         out_dat = in.data;
      end else begin
         out_vld = !empty && !flush;
         out_dat = rdata;
      end
      enq         = in.valid && in_rdy;
      deq         = out_vld && out.ready;
      bypass_take = bypass && enq && out.ready;
      wr_en       = enq && !bypass_take;
      rd_en       = deq && !bypass_take;
   end

   // Next pointers, occupancy and high-water mark; flush clears all of them.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      hwm_d    = hwm_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         hwm_d    = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(wr_en) - CW'(rd_en);
         if (count_d > hwm_q) hwm_d = count_d;
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hwm_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hwm_q    <= hwm_d;
      end
   end

   rv_fifo_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (in.data),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   assign in.ready  = in_rdy;
   assign out.valid = out_vld;
   assign out.data  = out_dat;
   assign count     = count_q;
   assign hwm       = hwm_q;

endmodule

// File: tb/tb_rv_elastic_fifo.sv
// Directed bench for rv_elastic_fifo: one registered instance and one fall-through instance.
// Inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Producer stability and occupancy bound are watched continuously on the registered instance.
module tb_rv_elastic_fifo;

   logic clk = 1'b0;
   logic rst;
   logic flush0, flush1;
   logic [2:0] count0, hwm0, count1, hwm1;
   logic full0, empty0, full1, empty1;
   int checks = 0;
   int errors = 0;

   rv_if #(.DW(32)) a_in ();
   rv_if #(.DW(32)) a_out ();
   rv_if #(.DW(32)) b_in ();
   rv_if #(.DW(32)) b_out ();

   always #5 clk = ~clk;

   rv_elastic_fifo #(.DW(32), .DEPTH(4), .PASSTHRU(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(flush0), .in(a_in), .out(a_out),
      .count(count0), .full(full0), .empty(empty0), .hwm(hwm0));

   rv_elastic_fifo #(.DW(32), .DEPTH(4), .PASSTHRU(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .flush(flush1), .in(b_in), .out(b_out),
      .count(count1), .full(full1), .empty(empty1), .hwm(hwm1));

   // Producer rule and occupancy bound on the registered instance.
   logic        p_vld, p_rdy, p_fl, p_rst;
   logic [31:0] p_dat;
   initial begin p_vld = 1'b0; p_rdy = 1'b0; p_fl = 1'b0; p_rst = 1'b1; p_dat = '0; end
   always @(negedge clk) begin
      if (p_vld && !p_rdy && !p_fl && !p_rst) begin
         if (a_in.valid !== 1'b1 || a_in.data !== p_dat) begin
            errors++;
            $display("FAIL producer_hold: valid=%b data=%h, required valid=1 data=%h", a_in.valid, a_in.data, p_dat);
         end
      end
      if (count0 > 3'd4) begin
         errors++;
         $display("FAIL count_bound: count=%0d, required <= 4", count0);
      end
      p_vld = a_in.valid; p_rdy = a_in.ready; p_fl = flush0; p_rst = rst; p_dat = a_in.data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      #1;
      checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d need 0", count0); end
      checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b need 1", empty0); end
      checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL rst_full: got %b need 0", full0); end
      checks++; if (hwm0 !== 3'd0) begin errors++; $display("FAIL rst_hwm: got %0d need 0", hwm0); end
      checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", a_out.valid); end
      checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_during: got %b need 0", a_in.ready); end
      checks++; if (b_in.ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_pt: got %b need 0", b_in.ready); end
      rst = 1'b0;
      #1;
      checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after: got %b need 1", a_in.ready); end
      tick();
   endtask

   task automatic test_fill_drain();
      a_out.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_in.valid = 1'b1;
         a_in.data  = 32'hA0 + 32'(i);
         #1;
         checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b need 1", i, a_in.ready); end
         tick();
      end
      a_in.valid = 1'b0;
      #1;
      checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b need 0", a_in.ready); end
      checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL full_flag: got %b need 1", full0); end
      checks++; if (count0 !== 3'd4) begin errors++; $display("FAIL full_count: got %0d need 4", count0); end
      checks++; if (hwm0 !== 3'd4) begin errors++; $display("FAIL full_hwm: got %0d need 4", hwm0); end
      a_out.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (a_out.valid !== 1'b1 || a_out.data !== 32'hA0 + 32'(i)) begin
            errors++; $display("FAIL drain[%0d]: valid=%b data=%h need valid=1 data=%h", i, a_out.valid, a_out.data, 32'hA0 + 32'(i));
         end
         if (i == 1) begin
            checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL unfull_in_ready: got %b need 1", a_in.ready); end
         end
         tick();
      end
      a_out.ready = 1'b0;
      #1;
      checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b need 1", empty0); end
      checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid: got %b need 0", a_out.valid); end
      checks++; if (hwm0 !== 3'd4) begin errors++; $display("FAIL drain_hwm_kept: got %0d need 4", hwm0); end
   endtask

   task automatic test_streaming();
      flush0 = 1'b1;
      tick();
      flush0 = 1'b0;
      #1;
      checks++; if (hwm0 !== 3'd0) begin errors++; $display("FAIL stream_pre_hwm: got %0d need 0", hwm0); end
      a_out.ready = 1'b1;
      for (int k = 0; k <= 100; k++) begin
         a_in.valid = (k < 100);
         a_in.data  = 32'(k);
         #1;
         if (k >= 1) begin
            checks++;
            if (a_out.valid !== 1'b1 || a_out.data !== 32'(k - 1) || count0 !== 3'd1) begin
               errors++; $display("FAIL stream[%0d]: valid=%b data=%h count=%0d need 1 %h 1", k, a_out.valid, a_out.data, count0, 32'(k - 1));
            end
         end
         tick();
      end
      a_in.valid  = 1'b0;
      a_out.ready = 1'b0;
      #1;
      checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d need 0", count0); end
      checks++; if (hwm0 !== 3'd1) begin errors++; $display("FAIL stream_hwm: got %0d need 1", hwm0); end
   endtask

   task automatic test_bypass();
      b_out.ready = 1'b1;
      b_in.valid  = 1'b1;
      b_in.data   = 32'h55;
      #1;
      checks++;
      if (b_out.valid !== 1'b1 || b_out.data !== 32'h55) begin
         errors++; $display("FAIL bypass_out: valid=%b data=%h need 1 55", b_out.valid, b_out.data);
      end
      checks++; if (b_in.ready !== 1'b1) begin errors++; $display("FAIL bypass_in_ready: got %b need 1", b_in.ready); end
      tick();
      b_in.valid = 1'b0;
      #1;
      checks++; if (count1 !== 3'd0 || empty1 !== 1'b1) begin errors++; $display("FAIL bypass_count: count=%0d empty=%b need 0 1", count1, empty1); end
      checks++; if (hwm1 !== 3'd0) begin errors++; $display("FAIL bypass_hwm: got %0d need 0", hwm1); end
      checks++; if (b_out.valid !== 1'b0) begin errors++; $display("FAIL bypass_idle_valid: got %b need 0", b_out.valid); end
      // Blocked consumer: the beat must be stored instead.
      b_out.ready = 1'b0;
      b_in.valid  = 1'b1;
      b_in.data   = 32'h66;
      tick();
      b_in.valid = 1'b0;
      #1;
      checks++;
      if (count1 !== 3'd1 || b_out.valid !== 1'b1 || b_out.data !== 32'h66) begin
         errors++; $display("FAIL bypass_store: count=%0d valid=%b data=%h need 1 1 66", count1, b_out.valid, b_out.data);
      end
      checks++; if (hwm1 !== 3'd1) begin errors++; $display("FAIL bypass_store_hwm: got %0d need 1", hwm1); end
      b_out.ready = 1'b1;
      tick();
      b_out.ready = 1'b0;
      #1;
      checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL bypass_drain_empty: got %b need 1", empty1); end
   endtask

   task automatic test_wrap();
      logic [31:0] sb[$];
      logic [31:0] exp_d;
      int sent = 0;
      int rcvd = 0;
      int cyc = 0;
      logic hs_in, hs_out;
      a_in.data = $urandom;
      while (rcvd < 1000 && cyc < 20000) begin
         a_out.ready = 1'($urandom_range(0, 1));
         a_in.valid  = (sent < 1000);
         #1;
         hs_in  = a_in.valid && a_in.ready;
         hs_out = a_out.valid && a_out.ready;
         if (hs_out) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL wrap_extra_beat: got %h with nothing outstanding", a_out.data);
            end else begin
               exp_d = sb.pop_front();
               if (a_out.data !== exp_d) begin
                  errors++; $display("FAIL wrap_data[%0d]: got %h need %h", rcvd, a_out.data, exp_d);
               end
            end
            rcvd++;
         end
         if (hs_in) begin
            sb.push_back(a_in.data);
            sent++;
         end
         tick();
         if (hs_in) a_in.data = $urandom;
         cyc++;
      end
      checks++; if (rcvd < 1000) begin errors++; $display("FAIL wrap_timeout: received %0d need 1000", rcvd); end
      a_in.valid  = 1'b0;
      a_out.ready = 1'b0;
      #1;
      checks++; if (count0 !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL wrap_residue: count=%0d left=%0d need 0 0", count0, sb.size()); end
   endtask

   task automatic test_flush();
      a_out.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_in.valid = 1'b1;
         a_in.data  = 32'hB0 + 32'(i);
         tick();
      end
      a_in.valid = 1'b0;
      #1;
      checks++; if (count0 !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d need 3", count0); end
      flush0      = 1'b1;
      a_in.valid  = 1'b1;
      a_in.data   = 32'hBF;
      a_out.ready = 1'b1;
      #1;
      checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b need 0", a_in.ready); end
      checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b need 0", a_out.valid); end
      tick();
      flush0     = 1'b0;
      a_in.valid = 1'b0;
      #1;
      checks++;
      if (count0 !== 3'd0 || hwm0 !== 3'd0 || empty0 !== 1'b1) begin
         errors++; $display("FAIL flush_after: count=%0d hwm=%0d empty=%b need 0 0 1", count0, hwm0, empty0);
      end
      for (int i = 0; i < 2; i++) begin
         checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: valid=%b data=%h need valid 0", i, a_out.valid, a_out.data); end
         tick();
      end
      a_in.valid = 1'b1;
      a_in.data  = 32'hC0;
      tick();
      a_in.valid = 1'b0;
      #1;
      checks++;
      if (a_out.valid !== 1'b1 || a_out.data !== 32'hC0) begin
         errors++; $display("FAIL flush_next_beat: valid=%b data=%h need 1 c0", a_out.valid, a_out.data);
      end
      tick();
      a_out.ready = 1'b0;
      #1;
      checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL flush_final_empty: got %b need 1", empty0); end
   endtask

   task automatic test_reset_mid();
      a_out.ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         a_in.valid = 1'b1;
         a_in.data  = 32'hD0 + 32'(i);
         tick();
      end
      a_in.valid = 1'b0;
      #1;
      checks++; if (count0 !== 3'd2) begin errors++; $display("FAIL rmid_pre_count: got %0d need 2", count0); end
      rst        = 1'b1;
      a_in.valid = 1'b1;
      a_in.data  = 32'hD2;
      #1;
      checks++; if (a_in.ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready_now: got %b need 0", a_in.ready); end
      tick();
      checks++;
      if (count0 !== 3'd0 || empty0 !== 1'b1 || full0 !== 1'b0 || hwm0 !== 3'd0 || a_out.valid !== 1'b0 || a_in.ready !== 1'b0) begin
         errors++; $display("FAIL rmid_state: count=%0d empty=%b full=%b hwm=%0d out_valid=%b in_ready=%b need 0 1 0 0 0 0",
                             count0, empty0, full0, hwm0, a_out.valid, a_in.ready);
      end
      rst        = 1'b0;
      a_in.valid = 1'b0;
      #1;
      checks++; if (a_in.ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready_after: got %b need 1", a_in.ready); end
      tick();
      checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost: valid=%b need 0", a_out.valid); end
   endtask

   initial begin
      rst = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
      a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
      b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
      test_reset();
      test_fill_drain();
      test_streaming();
      test_bypass();
      test_wrap();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
